// File: rtl/sum_accumulator.sv
// sum_accumulator: accumulates batches of N_OPS results from a 4-bit ripple adder.
// Each accepted result {C4,S} is zero-extended and added to a running total.
// Optional feature: define SUM_ACCUMULATOR_SATURATE_EN to clamp ACC at its maximum
// on overflow; otherwise ACC wraps. OVF is sticky for the batch in both builds.
module sum_accumulator #(
  parameter int unsigned N_OPS = 4,
  parameter int unsigned ACC_W = 8
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             START,
  input  logic [3:0]       S,
  input  logic             C4,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [ACC_W-1:0] ACC,
  output logic [3:0]       COUNT,
  output logic             DONE,
  output logic             OVF
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  localparam logic [3:0] LAST = 4'(N_OPS);

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [3:0]       count_q, count_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] operand;
  logic [ACC_W:0]   sum_ext;
  logic [3:0]       count_inc;

  // Operand and widened sum; the extra top bit is the overflow indicator.
  always_comb begin
    operand   = {{(ACC_W-5){1'b0}}, C4, S};
    sum_ext   = {1'b0, acc_q} + {1'b0, operand};
    count_inc = count_q + 4'd1;
  end

  // Next-state logic: batch start, transfers in RUN, single FIN cycle.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (IN_VALID) begin
          count_d = count_inc;
          ovf_d   = ovf_q | sum_ext[ACC_W];
`ifdef SUM_ACCUMULATOR_SATURATE_EN
          acc_d   = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
          acc_d   = sum_ext[ACC_W-1:0];
`endif
          if (count_inc == LAST) begin
            state_d = FIN;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs are pure functions of registered state.
  always_comb begin
    IN_READY = (state_q == RUN);
    DONE     = (state_q == FIN);
    ACC      = acc_q;
    COUNT    = count_q;
    OVF      = ovf_q;
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: three instances (N_OPS = 4, 15, 1) driven one at a time,
// checked every cycle against a true-sum model plus literal expectations.
module tb_sum_accumulator;

  localparam int AW  = 8;
  localparam int MAX = (1 << AW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst    [3];
  logic          start  [3];
  logic [3:0]    s      [3];
  logic          c4     [3];
  logic          valid  [3];
  logic          ready  [3];
  logic [AW-1:0] acc    [3];
  logic [3:0]    count  [3];
  logic          done   [3];
  logic          ovf    [3];

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  sum_accumulator #(.N_OPS(4), .ACC_W(AW)) u_n4 (
    .CLOCK(clk), .RESET(rst[0]), .START(start[0]), .S(s[0]), .C4(c4[0]),
    .IN_VALID(valid[0]), .IN_READY(ready[0]), .ACC(acc[0]), .COUNT(count[0]),
    .DONE(done[0]), .OVF(ovf[0])
  );
  sum_accumulator #(.N_OPS(15), .ACC_W(AW)) u_n15 (
    .CLOCK(clk), .RESET(rst[1]), .START(start[1]), .S(s[1]), .C4(c4[1]),
    .IN_VALID(valid[1]), .IN_READY(ready[1]), .ACC(acc[1]), .COUNT(count[1]),
    .DONE(done[1]), .OVF(ovf[1])
  );
  sum_accumulator #(.N_OPS(1), .ACC_W(AW)) u_n1 (
    .CLOCK(clk), .RESET(rst[2]), .START(start[2]), .S(s[2]), .C4(c4[2]),
    .IN_VALID(valid[2]), .IN_READY(ready[2]), .ACC(acc[2]), .COUNT(count[2]),
    .DONE(done[2]), .OVF(ovf[2])
  );

  // Behavioural model: phase 0 idle, 1 accepting, 2 finishing; keeps the unbounded sum.
  int nops     [3] = '{4, 15, 1};
  int m_phase  [3];
  int m_sum    [3];
  int m_cnt    [3];
  int done_seen[3];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst[i]) begin
        m_phase[i] = 0; m_sum[i] = 0; m_cnt[i] = 0;
      end else if (m_phase[i] == 0) begin
        if (start[i]) begin
          m_phase[i] = 1; m_sum[i] = 0; m_cnt[i] = 0;
        end
      end else if (m_phase[i] == 1) begin
        if (valid[i]) begin
          m_sum[i] += int'({c4[i], s[i]});
          m_cnt[i] += 1;
          if (m_cnt[i] == nops[i]) m_phase[i] = 2;
        end
      end else begin
        m_phase[i] = 0;
      end
    end
  end

  function automatic int exp_acc(int sum);
`ifdef SUM_ACCUMULATOR_SATURATE_EN
    return (sum > MAX) ? MAX : sum;
`else
    return sum % (MAX + 1);
`endif
  endfunction

  task automatic check(string name, int i, int act, int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s[u%0d] t=%0t got=%0d want=%0d", name, i, $time, act, want);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        check("ready", i, int'(ready[i]), int'(m_phase[i] == 1));
        check("done",  i, int'(done[i]),  int'(m_phase[i] == 2));
        check("acc",   i, int'(acc[i]),   exp_acc(m_sum[i]));
        check("count", i, int'(count[i]), m_cnt[i]);
        check("ovf",   i, int'(ovf[i]),   int'(m_sum[i] > MAX));
        if (done[i]) done_seen[i]++;
      end
    end
  end

  // One clock of stimulus on instance i; inputs change just after a falling edge.
  task automatic cyc(int i, bit r, bit st, bit v, int val);
    rst[i] = r; start[i] = st; valid[i] = v;
    {c4[i], s[i]} = 5'(val);
    @(negedge clk);
  endtask

  int vals[4] = '{5, 18, 31, 0};
  int d0;

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; start[i] = 1'b0; valid[i] = 1'b0; s[i] = '0; c4[i] = 1'b0;
      done_seen[i] = 0;
    end
    @(negedge clk);
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    // Reset state literals
    check("rst_acc", 0, int'(acc[0]), 0);
    check("rst_ready", 0, int'(ready[0]), 0);
    check("rst_done", 0, int'(done[0]), 0);

    // Basic batch, continuous valid
    cyc(0, 0, 1, 0, 0);
    foreach (vals[k]) cyc(0, 0, 0, 1, vals[k]);
    check("basic_done", 0, int'(done[0]), 1);
    cyc(0, 0, 0, 0, 0);
    check("basic_acc", 0, int'(acc[0]), 54);
    check("basic_count", 0, int'(count[0]), 4);
    check("basic_ovf", 0, int'(ovf[0]), 0);
    check("basic_pulses", 0, done_seen[0], 1);

    // Same values with two-cycle gaps
    cyc(0, 0, 1, 0, 0);
    foreach (vals[k]) begin
      cyc(0, 0, 0, 1, vals[k]);
      if (k < 3) begin
        cyc(0, 0, 0, 0, 7);
        cyc(0, 0, 0, 0, 7);
      end
    end
    cyc(0, 0, 0, 0, 0);
    check("gap_acc", 0, int'(acc[0]), 54);
    check("gap_pulses", 0, done_seen[0], 2);

    // Reset mid-batch, with START and a transfer in the reset cycle
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 9);
    cyc(0, 0, 0, 1, 10);
    check("mid_acc_pre", 0, int'(acc[0]), 19);
    cyc(0, 1, 1, 1, 11);
    check("mid_acc", 0, int'(acc[0]), 0);
    check("mid_count", 0, int'(count[0]), 0);
    check("mid_ready", 0, int'(ready[0]), 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("mid_pulses", 0, done_seen[0], 2);

    // START ignored in RUN and FIN, honoured in IDLE
    cyc(0, 0, 1, 0, 0);
    foreach (vals[k]) cyc(0, 0, 1, 1, vals[k]);
    cyc(0, 0, 1, 0, 0);
    check("ign_acc", 0, int'(acc[0]), 54);
    check("ign_count", 0, int'(count[0]), 4);
    check("ign_ready", 0, int'(ready[0]), 0);
    cyc(0, 0, 1, 0, 0);
    check("restart_acc", 0, int'(acc[0]), 0);
    check("restart_ready", 0, int'(ready[0]), 1);
    cyc(0, 1, 0, 0, 0);

    // Overflow: fifteen operands of 31
    cyc(1, 0, 1, 0, 0);
    for (int k = 0; k < 15; k++) cyc(1, 0, 0, 1, 31);
    cyc(1, 0, 0, 0, 0);
`ifdef SUM_ACCUMULATOR_SATURATE_EN
    check("ovf_acc", 1, int'(acc[1]), 255);
`else
    check("ovf_acc", 1, int'(acc[1]), 209);
`endif
    check("ovf_flag", 1, int'(ovf[1]), 1);
    check("ovf_count", 1, int'(count[1]), 15);
    check("ovf_pulses", 1, done_seen[1], 1);

    // N_OPS=1: one transfer finishes the batch
    cyc(2, 0, 1, 0, 0);
    cyc(2, 0, 0, 1, 23);
    check("one_done", 2, int'(done[2]), 1);
    check("one_acc", 2, int'(acc[2]), 23);
    cyc(2, 0, 0, 0, 0);
    check("one_pulses", 2, done_seen[2], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
